phoneme_sequencer: RTL and testbench

Playback controller between the PicoBlaze soft processor and the flash-resident phoneme sample store. On a start strobe it looks up a phoneme code's word range in an external address table, fetches 32-bit words from flash over an Avalon-MM read master, and emits two 16-bit signed samples per word, paced by the audio sample tick. When the last sample has been issued it raises a one-cycle done pulse, which the processor's interrupt logic uses as its event source.

---
 rtl/phoneme_sequencer.sv | 147 ++++++++++++++
 tb/tb_phoneme_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phoneme_sequencer.sv
// phoneme_sequencer: looks up a phoneme's flash word range and plays its 16-bit samples on the audio tick
module phoneme_sequencer #(
    parameter int ADDR_W      = 23,
    parameter int PAUSE_WORDS = 2000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        phoneme_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        tbl_addr_o,
    input  logic [ADDR_W-1:0] tbl_start_i,
    input  logic [ADDR_W-1:0] tbl_end_i,
    output logic              flash_read_o,
    output logic [ADDR_W-1:0] flash_addr_o,
    input  logic              flash_waitrequest_i,
    input  logic [31:0]       flash_readdata_i,
    input  logic              flash_readdatavalid_i,
    input  logic              sample_tick_i,
    output logic [15:0]       audio_sample_o,
    output logic              sample_valid_o
);
    typedef enum logic [3:0] {
        IDLE, LOOKUP, LOOKUP_WAIT, READ_REQ, READ_WAIT, PLAY_LO, PLAY_HI, PAUSE, DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cur_addr_q, end_addr_q, flash_addr_q;
    logic [31:0]       word_q, pause_cnt_q;
    logic [15:0]       audio_q;
    logic [7:0]        tbl_addr_q;
    logic              busy_q, done_q, flash_read_q, sample_valid_q, half_q, pend_q, pend_d;
    logic              step, consume;

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign tbl_addr_o     = tbl_addr_q;
    assign flash_read_o   = flash_read_q;
    assign flash_addr_o   = flash_addr_q;
    assign audio_sample_o = audio_q;
    assign sample_valid_o = sample_valid_q;

    // one-deep tick store: a step eats the stored tick first, so a coincident live tick is kept
    always_comb begin
        step    = sample_tick_i || pend_q;
        consume = (state_q == PLAY_LO || state_q == PLAY_HI || state_q == PAUSE) && step;
        pend_d  = (state_q == IDLE || state_q == DONE) ? 1'b0 :
                  consume ? (pend_q & sample_tick_i) : (pend_q | sample_tick_i);
    end

    // playback FSM; DONE is the cycle before the done pulse so done trails the last sample by one cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            flash_read_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            audio_q        <= '0;
            tbl_addr_q     <= '0;
            flash_addr_q   <= '0;
            cur_addr_q     <= '0;
            end_addr_q     <= '0;
            word_q         <= '0;
            pause_cnt_q    <= '0;
            half_q         <= 1'b0;
            pend_q         <= 1'b0;
        end else begin
            pend_q         <= pend_d;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start_i && !busy_q) begin
                        busy_q <= 1'b1;
                        if (phoneme_i == 8'h00) begin
                            pause_cnt_q <= 32'(PAUSE_WORDS);
                            half_q      <= 1'b0;
                            state_q     <= PAUSE;
                        end else begin
                            tbl_addr_q <= phoneme_i;
                            state_q    <= LOOKUP;
                        end
                    end
                end
                LOOKUP: state_q <= LOOKUP_WAIT;
                LOOKUP_WAIT: begin
                    cur_addr_q <= tbl_start_i;
                    end_addr_q <= tbl_end_i;
                    state_q    <= (tbl_end_i < tbl_start_i) ? DONE : READ_REQ;
                end
                READ_REQ: begin
                    if (!flash_read_q) begin
                        flash_read_q <= 1'b1;
                        flash_addr_q <= cur_addr_q;
                    end else if (!flash_waitrequest_i) begin
                        flash_read_q <= 1'b0;
                        state_q      <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (flash_readdatavalid_i) begin
                        word_q  <= flash_readdata_i;
                        state_q <= PLAY_LO;
                    end
                end
                PLAY_LO: begin
                    if (step) begin
                        audio_q        <= word_q[15:0];
                        sample_valid_q <= 1'b1;
                        state_q        <= PLAY_HI;
                    end
                end
                PLAY_HI: begin
                    if (step) begin
                        audio_q        <= word_q[31:16];
                        sample_valid_q <= 1'b1;
                        if (cur_addr_q == end_addr_q) begin
                            state_q <= DONE;
                        end else begin
                            cur_addr_q <= cur_addr_q + 1'b1;
                            state_q    <= READ_REQ;
                        end
                    end
                end
                PAUSE: begin
                    if (step) begin
                        audio_q        <= '0;
                        sample_valid_q <= 1'b1;
                        half_q         <= !half_q;
                        if (half_q) begin
                            pause_cnt_q <= pause_cnt_q - 32'd1;
                            if (pause_cnt_q <= 32'd1) state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phoneme_sequencer.sv
// tb_phoneme_sequencer: table vectors, hand-timed tick/reset sequences and randomized phonemes vs a range model
module tb_phoneme_sequencer;
    localparam int PW = 3;

    typedef struct {
        logic [7:0]  ph;
        logic [22:0] s;
        logic [22:0] e;
        int          stall;
        int          lat;
        int          n;
        logic [15:0] first;
        logic [15:0] last;
        int          nrd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1, start_i = 1'b0;
    logic [7:0]  phoneme_i = '0;
    logic        busy_o, done_o, flash_read_o, sample_valid_o;
    logic [7:0]  tbl_addr_o;
    logic [22:0] tbl_start_i = '0, tbl_end_i = '0, flash_addr_o;
    logic        flash_waitrequest_i = 1'b0, flash_readdatavalid_i = 1'b0, sample_tick_i = 1'b0;
    logic [31:0] flash_readdata_i = '0;
    logic [15:0] audio_sample_o;

    phoneme_sequencer #(.ADDR_W(23), .PAUSE_WORDS(PW)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .phoneme_i(phoneme_i),
        .busy_o(busy_o), .done_o(done_o), .tbl_addr_o(tbl_addr_o),
        .tbl_start_i(tbl_start_i), .tbl_end_i(tbl_end_i),
        .flash_read_o(flash_read_o), .flash_addr_o(flash_addr_o),
        .flash_waitrequest_i(flash_waitrequest_i), .flash_readdata_i(flash_readdata_i),
        .flash_readdatavalid_i(flash_readdatavalid_i), .sample_tick_i(sample_tick_i),
        .audio_sample_o(audio_sample_o), .sample_valid_o(sample_valid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0, checks = 0;
    logic [22:0] tbl_s [256];
    logic [22:0] tbl_e [256];
    logic [31:0] fmem [int];
    bit          tick_at [int];
    int          tick_per = 20, tick_ph = 3;
    int          stall_cfg = 0, stall_left = 0, lat_cfg = 1;
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    logic [22:0] rd_q [$];
    logic [22:0] exp_rd [$];
    int          resp_due [$];
    logic [31:0] resp_dat [$];
    int          done_cnt, done_cyc, sv_first, sv_last, busy_rise, busy_fall, rd_first, hold_err;
    logic        busy_prev = 1'b0, hold_prev = 1'b0;
    logic [22:0] hold_addr = '0;
    logic [7:0]  tbl_prev = '0;
    vec_t        vecs [7];

    function automatic logic [31:0] fword(input logic [22:0] a);
        if (fmem.exists(int'(a))) return fmem[int'(a)];
        return {a[15:0] ^ 16'h5A5A, a[22:7]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observe outputs and drive the table, flash slave and tick for the current cycle.
    always @(negedge clk) begin
        if (sample_valid_o === 1'b1) begin
            got_q.push_back(audio_sample_o);
            sv_last = cyc;
            if (sv_first < 0) sv_first = cyc;
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_o === 1'b1 && !busy_prev) busy_rise = cyc;
        if (busy_o === 1'b0 && busy_prev) busy_fall = cyc;
        busy_prev = (busy_o === 1'b1);
        if (flash_read_o === 1'b1 && rd_first < 0) rd_first = cyc;
        if (hold_prev && (flash_read_o !== 1'b1 || flash_addr_o !== hold_addr)) hold_err++;
        flash_waitrequest_i = (flash_read_o === 1'b1) && stall_left > 0;
        if (flash_waitrequest_i) stall_left--;
        if (flash_read_o === 1'b1 && !flash_waitrequest_i) begin
            rd_q.push_back(flash_addr_o);
            resp_due.push_back(cyc + lat_cfg);
            resp_dat.push_back(fword(flash_addr_o));
            stall_left = stall_cfg;
        end
        hold_prev = (flash_read_o === 1'b1) && flash_waitrequest_i;
        hold_addr = flash_addr_o;
        flash_readdatavalid_i = 1'b0;
        flash_readdata_i = 32'hDEAD_BEEF;
        if (resp_due.size() > 0 && resp_due[0] == cyc) begin
            flash_readdatavalid_i = 1'b1;
            flash_readdata_i = resp_dat[0];
            void'(resp_due.pop_front());
            void'(resp_dat.pop_front());
        end
        tbl_start_i = tbl_s[tbl_prev];
        tbl_end_i = tbl_e[tbl_prev];
        tbl_prev = tbl_addr_o;
        sample_tick_i = (tick_per != 0 && (cyc % tick_per) == tick_ph) || tick_at.exists(cyc);
    end

    task automatic build_exp(input logic [7:0] ph);
        logic [31:0] w;
        exp_q.delete();
        exp_rd.delete();
        if (ph == 8'h00) begin
            repeat (2 * PW) exp_q.push_back(16'h0000);
        end else begin
            for (int a = int'(tbl_s[ph]); a <= int'(tbl_e[ph]); a++) begin
                w = fword(23'(a));
                exp_rd.push_back(23'(a));
                exp_q.push_back(w[15:0]);
                exp_q.push_back(w[31:16]);
            end
        end
    endtask

    task automatic begin_run(input logic [7:0] ph, input int stall, input int lat, output int n);
        @(posedge clk); #1;
        got_q.delete();
        rd_q.delete();
        tick_at.delete();
        done_cnt = 0; done_cyc = -1; sv_first = -1; sv_last = -1;
        busy_rise = -1; busy_fall = -1; rd_first = -1; hold_err = 0;
        stall_cfg = stall; stall_left = stall; lat_cfg = lat;
        build_exp(ph);
        @(posedge clk); #1;
        start_i = 1'b1;
        phoneme_i = ph;
        n = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        phoneme_i = 8'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_cyc(input int c);
        do begin
            @(posedge clk); #1;
        end while (cyc < c);
    endtask

    task automatic check_run(input string t, input int n);
        chk({t, "_done_count"}, done_cnt, 1);
        chk({t, "_n_samples"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_sample%0d", t, i), got_q[i], exp_q[i]);
        chk({t, "_n_reads"}, rd_q.size(), exp_rd.size());
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
            chk($sformatf("%s_read%0d", t, i), rd_q[i], exp_rd[i]);
        chk({t, "_busy_rise"}, busy_rise, n + 1);
        chk({t, "_busy_fall"}, busy_fall, done_cyc + 1);
        chk({t, "_hold_stable"}, hold_err, 0);
        if (exp_rd.size() > 0) chk({t, "_first_read"}, rd_first, n + 4);
        if (exp_q.size() > 0) chk({t, "_done_after_last"}, done_cyc, sv_last + 1);
        else chk({t, "_done_empty"}, done_cyc, n + 4);
    endtask

    task automatic check_idle(input string t);
        chk({t, "_busy"}, busy_o, 0);
        chk({t, "_done"}, done_o, 0);
        chk({t, "_flash_read"}, flash_read_o, 0);
        chk({t, "_sample_valid"}, sample_valid_o, 0);
        chk({t, "_audio"}, audio_sample_o, 0);
        chk({t, "_tbl_addr"}, tbl_addr_o, 0);
        chk({t, "_flash_addr"}, flash_addr_o, 0);
    endtask

    initial begin
        int n, k, len;
        logic [7:0]  ph;
        logic [22:0] s;
        vecs[0] = '{8'h05, 23'h100, 23'h101, 0, 1, 4, 16'hAAAA, 16'hDDDD, 2};
        vecs[1] = '{8'h09, 23'h200, 23'h1FF, 0, 1, 0, 16'h0000, 16'h0000, 0};
        vecs[2] = '{8'h00, 23'h000, 23'h000, 0, 1, 6, 16'h0000, 16'h0000, 0};
        vecs[3] = '{8'h05, 23'h100, 23'h101, 7, 1, 4, 16'hAAAA, 16'hDDDD, 2};
        vecs[4] = '{8'h33, 23'h300, 23'h300, 2, 3, 2, 16'h7FFF, 16'h8000, 1};
        vecs[5] = '{8'hFF, 23'h7FFFFF, 23'h7FFFFF, 0, 2, 2, 16'h5678, 16'h1234, 1};
        vecs[6] = '{8'h10, 23'h000, 23'h000, 1, 4, 2, 16'h0001, 16'hFFFF, 1};
        fmem[32'h100] = 32'hBBBB_AAAA;
        fmem[32'h101] = 32'hDDDD_CCCC;
        fmem[32'h300] = 32'h8000_7FFF;
        fmem[32'h7FFFFF] = 32'h1234_5678;
        fmem[0] = 32'hFFFF_0001;
        for (int i = 0; i < 256; i++) begin
            tbl_s[i] = 23'h1;
            tbl_e[i] = 23'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        reset_i = 1'b0;

        foreach (vecs[i]) begin
            tbl_s[vecs[i].ph] = vecs[i].s;
            tbl_e[vecs[i].ph] = vecs[i].e;
            begin_run(vecs[i].ph, vecs[i].stall, vecs[i].lat, n);
            wait_done(600);
            check_run($sformatf("vec%0d", i), n);
            chk($sformatf("vec%0d_n", i), got_q.size(), vecs[i].n);
            chk($sformatf("vec%0d_reads", i), rd_q.size(), vecs[i].nrd);
            if (vecs[i].n > 0) begin
                chk($sformatf("vec%0d_first", i), (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, vecs[i].first);
                chk($sformatf("vec%0d_last", i), (got_q.size() > 0) ? 32'(got_q[got_q.size()-1]) : 32'hFFFF_FFFF, vecs[i].last);
            end
        end
        tbl_s[8'h05] = 23'h100;
        tbl_e[8'h05] = 23'h101;

        // one tick stored during a late read is played the cycle after PLAY_LO entry
        tick_per = 0;
        begin_run(8'h05, 0, 6, n);
        tick_at[n+7] = 1'b1; tick_at[n+30] = 1'b1; tick_at[n+50] = 1'b1; tick_at[n+70] = 1'b1;
        wait_done(600);
        check_run("pend1", n);
        chk("pend1_first_sample_cyc", sv_first, n + 12);

        // two ticks during the wait: only one is retained
        begin_run(8'h05, 0, 6, n);
        tick_at[n+6] = 1'b1; tick_at[n+8] = 1'b1; tick_at[n+30] = 1'b1; tick_at[n+50] = 1'b1; tick_at[n+70] = 1'b1;
        wait_cyc(n + 25);
        chk("pend2_one_retained", got_q.size(), 1);
        wait_done(600);
        check_run("pend2", n);
        chk("pend2_first_sample_cyc", sv_first, n + 12);
        tick_per = 20;

        // start while busy is ignored
        begin_run(8'h05, 0, 1, n);
        start_i = 1'b1;
        phoneme_i = 8'h00;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(600);
        check_run("busy_start", n);

        // reset in READ_WAIT, then a late readdatavalid must be ignored
        begin_run(8'h05, 0, 8, n);
        wait_cyc(n + 6);
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("mid_reset");
        @(posedge clk); #1;
        reset_i = 1'b0;
        wait_cyc(n + 20);
        chk("post_reset_busy", busy_o, 0);
        chk("post_reset_audio", audio_sample_o, 0);
        chk("post_reset_samples", got_q.size(), 0);
        chk("post_reset_reads", rd_q.size(), 1);
        chk("post_reset_done", done_cnt, 0);
        chk("post_reset_resp_drained", resp_due.size(), 0);
        begin_run(8'h05, 0, 1, n);
        wait_done(600);
        check_run("after_reset", n);

        // randomized phonemes against the range model
        for (int it = 0; it < 16; it++) begin
            k = $urandom_range(0, 9);
            ph = (k == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            s = 23'($urandom_range(1, 32'h7FFFF0));
            len = $urandom_range(1, 3);
            tbl_s[ph] = s;
            tbl_e[ph] = (k == 1) ? s - 23'd1 : s + 23'(len - 1);
            tick_ph = $urandom_range(0, 19);
            begin_run(ph, $urandom_range(0, 3), $urandom_range(1, 4), n);
            wait_done(600);
            check_run($sformatf("rnd%0d", it), n);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
